// File: rtl/aes_byte_host.sv
// Byte-serial host for the AES core: wide key/plaintext in, 16 bytes out MSB first, 16 bytes back, wide ciphertext out.
// Optional WAIT timeout compiled in with `define AES_HOST_TIMEOUT_EN (err tied low otherwise).
module aes_byte_host #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic [127:0] data_in,
  output logic         busy,
  output logic         done,
  output logic [127:0] result_out,
  output logic         err,
  output logic         core_enable,
  output logic [7:0]   core_key_byte,
  output logic [7:0]   core_state_byte,
  input  logic         core_load,
  input  logic         core_ready,
  input  logic [7:0]   core_out_byte
);

  typedef enum logic [2:0] {IDLE, ARM, SEND, WAIT, COLLECT, DONE} state_t;

  state_t       state, state_next;
  logic [127:0] key_sr, data_sr, res_sr;
  logic [3:0]   cnt;
  logic         timeout;

`ifdef AES_HOST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] to_cnt;
  logic          err_q;

  // Counter is held at zero outside WAIT, so every WAIT entry starts a fresh window.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q  <= timeout;
      to_cnt <= (state == WAIT) ? to_cnt + 1'b1 : '0;
    end
  end

  assign timeout = (state == WAIT) && !core_ready && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign err     = err_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  // core_load is debug-only status; the parameter only matters with the timeout built in.
  logic unused_ok;
  assign unused_ok = &{1'b0, core_load, TIMEOUT_CYCLES[0]};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves state_next unassigned (no latch).
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = ARM;
      ARM:     state_next = SEND;
      SEND:    if (cnt == 4'd0) state_next = WAIT;
      WAIT: begin
        if (core_ready)   state_next = COLLECT;
        else if (timeout) state_next = IDLE;
      end
      COLLECT: if (core_ready && cnt == 4'd15) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: outbound shift registers carry no reset; they are always loaded on start before use.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      key_sr  <= key_in;
      data_sr <= data_in;
    end else if (state == SEND) begin
      key_sr  <= {key_sr[119:0], 8'h00};
      data_sr <= {data_sr[119:0], 8'h00};
    end
  end

  // cnt counts bytes left to send in SEND, then bytes already captured in COLLECT.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= 4'd0;
      res_sr     <= '0;
      result_out <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) cnt <= 4'd15;
        SEND: cnt <= cnt - 4'd1;
        WAIT: begin
          if (core_ready) begin
            res_sr <= {res_sr[119:0], core_out_byte};
            cnt    <= 4'd1;
          end
        end
        COLLECT: begin
          if (core_ready) begin
            res_sr <= {res_sr[119:0], core_out_byte};
            cnt    <= cnt + 4'd1;
            if (cnt == 4'd15) result_out <= {res_sr[119:0], core_out_byte};
          end
        end
        default: ;
      endcase
    end
  end

  assign busy            = (state != IDLE);
  assign done            = (state == DONE);
  assign core_enable     = (state == ARM) || (state == SEND) || (state == WAIT) || (state == COLLECT);
  assign core_key_byte   = (state == SEND) ? key_sr[127:120]  : 8'h00;
  assign core_state_byte = (state == SEND) ? data_sr[127:120] : 8'h00;

endmodule

// File: tb/tb_aes_byte_host.sv
// Scoreboard bench for aes_byte_host with a behavioural byte-serial core model.
// Timeout expectations follow whether AES_HOST_TIMEOUT_EN is defined for the build.
module tb_aes_byte_host;

  localparam int TO = 32;

  localparam logic [127:0] K1 = 128'h5468617473206D79204B756E67204675;
  localparam logic [127:0] D1 = 128'h54776F204F6E65204E696E652054776F;
  localparam logic [127:0] R1 = 128'h29C3505F571420F6402299B31A02D73A;
  localparam logic [127:0] K2 = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] D2 = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
  localparam logic [127:0] K3 = 128'hDEADBEEF0123456789ABCDEFFEDCBA98;
  localparam logic [127:0] D3 = 128'h80402010080402017F3F1F0F07030100;
  localparam logic [127:0] K4 = 128'hA5A5A5A55A5A5A5AC3C3C3C33C3C3C3C;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [127:0] key_in, data_in;
  logic         busy, done, err, core_enable;
  logic [127:0] result_out;
  logic [7:0]   core_key_byte, core_state_byte;
  logic         core_load, core_ready;
  logic [7:0]   core_out_byte;

  aes_byte_host #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in), .data_in(data_in),
    .busy(busy), .done(done), .result_out(result_out), .err(err),
    .core_enable(core_enable), .core_key_byte(core_key_byte), .core_state_byte(core_state_byte),
    .core_load(core_load), .core_ready(core_ready), .core_out_byte(core_out_byte)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int base = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Scoreboard: expected result and the absolute cycle its done pulse must appear in.
  typedef struct {
    logic [127:0] res;
    int           at;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
      end else begin
        e = sb.pop_front();
        check("done_result", result_out, e.res);
        check("done_cycle", 128'(cyc), 128'(e.at));
      end
    end
  end

  // Core model: samples bytes from the cycle after enable rises, answers after a delay.
  logic [7:0]   rx [16];
  int           phase = 0, rx_cnt = 0, tx_idx = 0, dly = 0, gap = 0;
  int           lat = 6, stall_at = -1, stall_len = 0;
  bit           no_ready = 1'b0, fixed_mode = 1'b0;
  logic [127:0] fixed_resp = '0;

  always @(negedge clk) begin
    core_ready    = 1'b0;
    core_out_byte = 8'hFF;
    if (rst || !core_enable) begin
      phase = 0;
    end else begin
      if (phase == 2) begin
        dly--;
        if (dly == 0) begin
          phase  = 3;
          tx_idx = 0;
          gap    = 0;
        end
      end
      if (phase == 3) begin
        if (gap > 0) gap--;
        else if (tx_idx < 16) begin
          core_ready    = 1'b1;
          core_out_byte = fixed_mode ? fixed_resp[127 - 8*tx_idx -: 8] : rx[tx_idx];
          tx_idx++;
          if (tx_idx == stall_at) gap = stall_len;
        end
      end
      if (phase == 1) begin
        rx[rx_cnt] = core_key_byte ^ core_state_byte;
        rx_cnt++;
        if (rx_cnt == 16) begin
          phase = no_ready ? 4 : 2;
          dly   = lat;
        end
      end
      if (phase == 0) begin
        phase  = 1;
        rx_cnt = 0;
      end
    end
  end

  // Returns at the falling edge of cycle 1 (cycle 0 = edge sampling start).
  task automatic start_op(input logic [127:0] k, input logic [127:0] d, input bit expect_done,
                          input logic [127:0] exp_res, input int done_cyc);
    @(negedge clk);
    key_in  = k;
    data_in = d;
    start   = 1'b1;
    @(posedge clk);
    #1;
    base = cyc;
    if (expect_done) sb.push_back('{exp_res, base + done_cyc - 1});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic goto(input int n);
    while (cyc - base + 1 < n) @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while ((sb.size() != 0 || busy !== 1'b0) && k < 300) begin
      @(negedge clk);
      k++;
    end
    check(name, 128'(k < 300), 128'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},   128'(busy),            128'd0);
    check({tag, "_done"},   128'(done),            128'd0);
    check({tag, "_err"},    128'(err),             128'd0);
    check({tag, "_result"}, result_out,            128'd0);
    check({tag, "_enable"}, 128'(core_enable),     128'd0);
    check({tag, "_keyb"},   128'(core_key_byte),   128'd0);
    check({tag, "_stateb"}, 128'(core_state_byte), 128'd0);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached, required self-termination");
    $fatal(1);
  end

  bit ok;

  initial begin
    rst = 1'b1; start = 1'b0; key_in = '0; data_in = '0; core_load = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Nominal vector; the model answers with the known ciphertext.
    fixed_mode = 1'b1;
    fixed_resp = R1;
    start_op(K1, D1, 1'b1, R1, 39);
    check("c1_enable", 128'(core_enable),     128'd1);
    check("c1_busy",   128'(busy),            128'd1);
    check("c1_keyb",   128'(core_key_byte),   128'd0);
    check("c1_stateb", 128'(core_state_byte), 128'd0);
    goto(2);
    check("c2_keyb",   128'(core_key_byte),   128'h54);
    check("c2_stateb", 128'(core_state_byte), 128'h54);
    goto(17);
    check("c17_keyb",   128'(core_key_byte),   128'h75);
    check("c17_stateb", 128'(core_state_byte), 128'h6F);
    goto(18);
    check("c18_keyb",   128'(core_key_byte),   128'd0);
    check("c18_stateb", 128'(core_state_byte), 128'd0);
    check("c18_enable", 128'(core_enable),     128'd1);
    wait_idle("op1_complete");
    @(negedge clk);
    check("op1_result_held", result_out,       R1);
    check("op1_done_low",    128'(done),       128'd0);
    check("op1_enable_low",  128'(core_enable), 128'd0);

    // Echo model: result is key xor data.
    fixed_mode = 1'b0;
    start_op(K2, D2, 1'b1, K2 ^ D2, 39);
    wait_idle("op2_complete");

    // Ready gap of 3 cycles after 8 output bytes.
    stall_at  = 8;
    stall_len = 3;
    start_op(K3, D3, 1'b1, K3 ^ D3, 42);
    wait_idle("op3_complete");
    stall_at = -1;

    // start during SEND must not disturb the block in flight.
    start_op(K4, D2, 1'b1, K4 ^ D2, 39);
    goto(5);
    key_in  = ~K4;
    data_in = ~D2;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("op4_complete");

    // Reset during COLLECT discards the operation.
    start_op(K2, D3, 1'b0, '0, 0);
    goto(28);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("midrun_reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("after_reset_idle", 128'(busy), 128'd0);
    start_op(K3, D2, 1'b1, K3 ^ D2, 39);
    wait_idle("op5_complete");

    // Core never answers.
    no_ready = 1'b1;
    start_op(K1, D2, 1'b0, '0, 0);
`ifdef AES_HOST_TIMEOUT_EN
    goto(49);
    check("to_c49_err",  128'(err),  128'd0);
    check("to_c49_busy", 128'(busy), 128'd1);
    goto(50);
    check("to_c50_err",    128'(err),         128'd1);
    check("to_c50_busy",   128'(busy),        128'd0);
    check("to_c50_enable", 128'(core_enable), 128'd0);
    check("to_c50_done",   128'(done),        128'd0);
    check("to_c50_result", result_out,        K3 ^ D2);
    goto(51);
    check("to_c51_err",  128'(err),  128'd0);
    check("to_c51_busy", 128'(busy), 128'd0);
`else
    ok = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!(busy === 1'b1 && err === 1'b0 && core_enable === 1'b1)) ok = 1'b0;
    end
    check("wait_holds_2000", 128'(ok), 128'd1);
    check("wait_result_kept", result_out, K3 ^ D2);
`endif
    no_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("final_reset_idle", 128'(busy), 128'd0);

    start_op(K4, D1, 1'b1, K4 ^ D1, 39);
    wait_idle("op6_complete");
    check("scoreboard_empty", 128'(sb.size()), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
